// File: rtl/morse_pkg.sv
// Shared element codes, FSM state encoding and width helper for the Morse decoder.
package morse_pkg;

  localparam logic [1:0] ELEM_NONE = 2'b00;
  localparam logic [1:0] ELEM_DOT  = 2'b01;
  localparam logic [1:0] ELEM_DASH = 2'b10;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    MARK  = 2'd1,
    SPACE = 2'd2
  } state_e;

  // Width needed to hold an element count of 0..max_elems.
  function automatic int unsigned len_w(input int unsigned max_elems);
    return $clog2(max_elems + 1);
  endfunction

endpackage

// File: rtl/morse_tick_gen.sv
// Key-line synchroniser and free-running sample tick enable.
module morse_tick_gen #(
  parameter int unsigned CLK_DIV = 4
) (
  input  logic clk,
  input  logic rst,
  input  logic serial_inp,
  output logic key_s,
  output logic tick
);

  localparam int unsigned DIV_W = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
  localparam logic [DIV_W-1:0] LAST = DIV_W'(CLK_DIV - 1);

  logic [1:0]       sync_q;
  logic [DIV_W-1:0] div_cnt;
  logic [DIV_W-1:0] div_nx;

  always_comb div_nx = (div_cnt == LAST) ? '0 : div_cnt + DIV_W'(1);

  // tick is high for the one clk in which div_cnt sits at CLK_DIV-1
  always_ff @(posedge clk) begin
    if (!rst) begin
      sync_q  <= '0;
      div_cnt <= '0;
      tick    <= 1'b0;
    end else begin
      sync_q  <= {sync_q[0], serial_inp};
      div_cnt <= div_nx;
      tick    <= (div_nx == LAST);
    end
  end

  assign key_s = sync_q[1];

endmodule

// File: rtl/morse_element_decoder.sv
// Classifies keyed marks into dots/dashes, assembles letters and flags letter/word gaps.
module morse_element_decoder
  import morse_pkg::*;
#(
  parameter int unsigned CLK_DIV       = 4,
  parameter int unsigned CNT_W         = 8,
  parameter int unsigned DASH_TH       = 2,
  parameter int unsigned LETTER_GAP_TH = 2,
  parameter int unsigned WORD_GAP_TH   = 5,
  parameter int unsigned MAX_ELEMS     = 6
) (
  input  logic                           clk,
  input  logic                           rst,
  input  logic                           serial_inp,
  output logic                           elem_valid,
  output logic [1:0]                     elem_code,
  output logic                           letter_valid,
  input  logic                           letter_ready,
  output logic [MAX_ELEMS-1:0]           letter_bits,
  output logic [len_w(MAX_ELEMS)-1:0]    letter_len,
  output logic                           letter_err,
  output logic                           word_gap,
  output logic                           overrun
);

  localparam int unsigned LEN_W = len_w(MAX_ELEMS);
  localparam logic [CNT_W-1:0] CNT_MAX = '1;

  logic key_s;
  logic tick;

  morse_tick_gen #(.CLK_DIV(CLK_DIV)) u_tick_gen (
    .clk        (clk),
    .rst        (rst),
    .serial_inp (serial_inp),
    .key_s      (key_s),
    .tick       (tick)
  );

  state_e               state, state_nx;
  logic [CNT_W-1:0]     mark_cnt, mark_nx;
  logic [CNT_W-1:0]     space_cnt, space_nx;
  logic [MAX_ELEMS-1:0] elem_buf, buf_nx;
  logic [LEN_W-1:0]     elem_cnt, ecnt_nx;
  logic                 err_flag, err_nx;
  logic                 word_armed, armed_nx;
  logic                 elem_valid_nx;
  logic [1:0]           elem_code_nx;
  logic                 letter_valid_nx;
  logic [MAX_ELEMS-1:0] bits_nx;
  logic [LEN_W-1:0]     len_nx;
  logic                 lerr_nx;
  logic                 word_gap_nx;
  logic                 overrun_nx;
  logic                 is_dash;

  always_ff @(posedge clk) begin
    if (!rst) begin
      state        <= IDLE;
      mark_cnt     <= '0;
      space_cnt    <= '0;
      elem_buf     <= '0;
      elem_cnt     <= '0;
      err_flag     <= 1'b0;
      word_armed   <= 1'b0;
      elem_valid   <= 1'b0;
      elem_code    <= ELEM_NONE;
      letter_valid <= 1'b0;
      letter_bits  <= '0;
      letter_len   <= '0;
      letter_err   <= 1'b0;
      word_gap     <= 1'b0;
      overrun      <= 1'b0;
    end else begin
      state        <= state_nx;
      mark_cnt     <= mark_nx;
      space_cnt    <= space_nx;
      elem_buf     <= buf_nx;
      elem_cnt     <= ecnt_nx;
      err_flag     <= err_nx;
      word_armed   <= armed_nx;
      elem_valid   <= elem_valid_nx;
      elem_code    <= elem_code_nx;
      letter_valid <= letter_valid_nx;
      letter_bits  <= bits_nx;
      letter_len   <= len_nx;
      letter_err   <= lerr_nx;
      word_gap     <= word_gap_nx;
      overrun      <= overrun_nx;
    end
  end

  // Next-state and registered-output logic; run-length updates only on tick.
  always_comb begin
    state_nx        = state;
    mark_nx         = mark_cnt;
    space_nx        = space_cnt;
    buf_nx          = elem_buf;
    ecnt_nx         = elem_cnt;
    err_nx          = err_flag;
    armed_nx        = word_armed;
    elem_valid_nx   = 1'b0;
    elem_code_nx    = ELEM_NONE;
    letter_valid_nx = letter_valid && !letter_ready;
    bits_nx         = letter_bits;
    len_nx          = letter_len;
    lerr_nx         = letter_err;
    word_gap_nx     = 1'b0;
    overrun_nx      = overrun;
    is_dash         = (mark_cnt >= CNT_W'(DASH_TH));

    if (tick) begin
      unique case (state)
        IDLE: begin
          if (key_s) begin
            state_nx = MARK;
            mark_nx  = CNT_W'(1);
          end
        end
        MARK: begin
          if (key_s) begin
            if (mark_cnt != CNT_MAX) mark_nx = mark_cnt + CNT_W'(1);
          end else begin
            elem_valid_nx = 1'b1;
            elem_code_nx  = is_dash ? ELEM_DASH : ELEM_DOT;
            if (elem_cnt < LEN_W'(MAX_ELEMS)) begin
              buf_nx[elem_cnt] = is_dash;
              ecnt_nx          = elem_cnt + LEN_W'(1);
            end else begin
              err_nx = 1'b1;
            end
            state_nx = SPACE;
            space_nx = CNT_W'(1);
          end
        end
        SPACE: begin
          if (key_s) begin
            state_nx = MARK;
            mark_nx  = CNT_W'(1);
          end else begin
            if (space_cnt != CNT_MAX) space_nx = space_cnt + CNT_W'(1);
            if (space_nx == CNT_W'(LETTER_GAP_TH)) begin
              // a letter arriving on the same clk as an accept is not an overrun
              if (!letter_valid || letter_ready) begin
                letter_valid_nx = 1'b1;
                bits_nx         = elem_buf;
                len_nx          = elem_cnt;
                lerr_nx         = err_flag;
                armed_nx        = 1'b1;
              end else begin
                overrun_nx = 1'b1;
              end
              buf_nx  = '0;
              ecnt_nx = '0;
              err_nx  = 1'b0;
            end
            if (space_nx == CNT_W'(WORD_GAP_TH)) begin
              if (word_armed) begin
                word_gap_nx = 1'b1;
                armed_nx    = 1'b0;
              end
              state_nx = IDLE;
            end
          end
        end
        default: state_nx = IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_morse_element_decoder.sv
// Scoreboard bench: stimulus queues expected elements/letters/word gaps, a monitor checks them.
module tb_morse_element_decoder;
  import morse_pkg::*;

  localparam int unsigned CLK_DIV   = 4;
  localparam int unsigned MAX_ELEMS = 6;
  localparam int unsigned LEN_W     = len_w(MAX_ELEMS);

  typedef struct packed {
    logic [MAX_ELEMS-1:0] bits;
    logic [LEN_W-1:0]     len;
    logic                 err;
  } letter_t;

  logic                 clk = 1'b0;
  logic                 rst;
  logic                 serial_inp;
  logic                 letter_ready;
  logic                 elem_valid;
  logic [1:0]           elem_code;
  logic                 letter_valid;
  logic [MAX_ELEMS-1:0] letter_bits;
  logic [LEN_W-1:0]     letter_len;
  logic                 letter_err;
  logic                 word_gap;
  logic                 overrun;

  int checks = 0;
  int errors = 0;
  logic [1:0] exp_elem[$];
  letter_t    exp_let[$];
  int         exp_wgap = 0;

  morse_element_decoder #(.CLK_DIV(CLK_DIV), .MAX_ELEMS(MAX_ELEMS)) u_dut (
    .clk          (clk),
    .rst          (rst),
    .serial_inp   (serial_inp),
    .elem_valid   (elem_valid),
    .elem_code    (elem_code),
    .letter_valid (letter_valid),
    .letter_ready (letter_ready),
    .letter_bits  (letter_bits),
    .letter_len   (letter_len),
    .letter_err   (letter_err),
    .word_gap     (word_gap),
    .overrun      (overrun)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic unexpected(input string name);
    checks++;
    errors++;
    $display("FAIL %s: output seen with nothing expected", name);
  endtask

  // Monitor: one pop per element pulse, per accepted letter and per word-gap pulse.
  always @(negedge clk) begin
    if (rst) begin
      if (elem_valid) begin
        if (exp_elem.size() == 0) unexpected("elem_unexpected");
        else check("elem_code", 32'(elem_code), 32'(exp_elem.pop_front()));
      end
      if (letter_valid && letter_ready) begin
        if (exp_let.size() == 0) unexpected("letter_unexpected");
        else check("letter_bits_len_err", 32'({letter_bits, letter_len, letter_err}),
                   32'(exp_let.pop_front()));
      end
      if (word_gap) begin
        checks++;
        if (exp_wgap == 0) begin
          errors++;
          $display("FAIL word_gap: pulse seen, expected none");
        end else begin
          exp_wgap--;
        end
      end
    end
  end

  task automatic step(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic seg(input logic v, input int ticks);
    serial_inp = v;
    step(ticks * CLK_DIV);
  endtask

  task automatic push_letter(input logic [MAX_ELEMS-1:0] b, input int l, input logic e);
    letter_t t;
    t.bits = b;
    t.len  = LEN_W'(l);
    t.err  = e;
    exp_let.push_back(t);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not complete, got timeout, expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    rst = 1'b0;
    serial_inp = 1'b0;
    letter_ready = 1'b1;
    step(3);
    check("rst_letter_valid", 32'(letter_valid), 0);
    check("rst_overrun", 32'(overrun), 0);
    check("rst_elem_code", 32'(elem_code), 0);
    check("rst_others", 32'({elem_valid, letter_bits, letter_len, letter_err, word_gap}), 0);
    rst = 1'b1;
    step(2);

    // "A": dot, dash, then word gap
    exp_elem.push_back(ELEM_DOT);
    exp_elem.push_back(ELEM_DASH);
    push_letter(6'b000010, 2, 1'b0);
    exp_wgap++;
    seg(1'b1, 1); seg(1'b0, 1); seg(1'b1, 3); seg(1'b0, 6);
    step(4);

    // "S" + "T" with a 2-tick letter gap
    repeat (3) exp_elem.push_back(ELEM_DOT);
    push_letter(6'b000000, 3, 1'b0);
    exp_elem.push_back(ELEM_DASH);
    push_letter(6'b000001, 1, 1'b0);
    exp_wgap++;
    seg(1'b1, 1); seg(1'b0, 1);
    seg(1'b1, 1); seg(1'b0, 1);
    seg(1'b1, 1); seg(1'b0, 2);
    seg(1'b1, 3); seg(1'b0, 6);
    step(4);

    // 7 dots: 7th element dropped, err set
    repeat (7) exp_elem.push_back(ELEM_DOT);
    push_letter(6'b000000, 6, 1'b1);
    exp_wgap++;
    for (int i = 0; i < 7; i++) begin
      seg(1'b1, 1);
      seg(1'b0, (i == 6) ? 6 : 1);
    end
    step(4);

    // completion of T on the same clk that E is accepted
    letter_ready = 1'b0;
    exp_elem.push_back(ELEM_DOT);
    exp_elem.push_back(ELEM_DASH);
    push_letter(6'b000000, 1, 1'b0);
    push_letter(6'b000001, 1, 1'b0);
    exp_wgap++;
    fork
      begin
        seg(1'b1, 1); seg(1'b0, 2); seg(1'b1, 3); seg(1'b0, 6);
      end
      begin
        bit seen = 1'b0;
        for (int i = 0; i < 400 && !seen; i++) begin
          @(negedge clk);
          if (elem_valid && elem_code == ELEM_DASH) seen = 1'b1;
        end
        if (!seen) begin
          unexpected("same_clk_dash_timeout");
        end else begin
          // the completing tick is CLK_DIV clks after the dash-deciding tick
          repeat (3) @(posedge clk);
          #1 letter_ready = 1'b1;
          @(posedge clk);
          #1 letter_ready = 1'b0;
          @(negedge clk);
          check("same_clk_valid", 32'(letter_valid), 1);
          check("same_clk_bits", 32'(letter_bits), 32'(6'b000001));
          check("same_clk_len", 32'(letter_len), 1);
          check("same_clk_overrun", 32'(overrun), 0);
        end
        letter_ready = 1'b1;
      end
    join
    step(4);

    // overrun: E held, T lost
    letter_ready = 1'b0;
    exp_elem.push_back(ELEM_DOT);
    exp_elem.push_back(ELEM_DASH);
    push_letter(6'b000000, 1, 1'b0);
    exp_wgap++;
    seg(1'b1, 1); seg(1'b0, 2); seg(1'b1, 3);
    check("hold_mid_valid", 32'({letter_valid, letter_bits, letter_len}), 32'({1'b1, 6'b000000, 3'd1}));
    check("hold_mid_overrun", 32'(overrun), 0);
    seg(1'b0, 6);
    check("hold_end_valid", 32'(letter_valid), 1);
    check("hold_end_payload", 32'({letter_bits, letter_len, letter_err}), 32'({6'b000000, 3'd1, 1'b0}));
    check("overrun_set", 32'(overrun), 1);
    letter_ready = 1'b1;
    step(3);
    check("after_accept_valid", 32'(letter_valid), 0);
    check("overrun_sticky", 32'(overrun), 1);

    // reset in the middle of a dash
    seg(1'b1, 2);
    rst = 1'b0;
    serial_inp = 1'b0;
    step(1);
    check("midrst_overrun", 32'(overrun), 0);
    check("midrst_outputs", 32'({elem_valid, elem_code, letter_valid, letter_bits, letter_len,
                                  letter_err, word_gap}), 0);
    rst = 1'b1;
    seg(1'b0, 3);
    exp_elem.push_back(ELEM_DOT);
    push_letter(6'b000000, 1, 1'b0);
    exp_wgap++;
    seg(1'b1, 1); seg(1'b0, 6);
    step(4);

    check("elem_queue_empty", 32'(exp_elem.size()), 0);
    check("letter_queue_empty", 32'(exp_let.size()), 0);
    check("word_gap_pending", 32'(exp_wgap), 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
